// File: rtl/uart_echo_pkg.sv
// rtl/uart_echo_pkg.sv - shared state encodings and ASCII case helpers for the UART echo responder
package uart_echo_pkg;

  typedef enum logic {
    RX_IDLE,
    RX_CLR
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_t;

  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7A;
  localparam int         CASE_BIT   = 5;

  // Lower-case ASCII letters lose their case bit; everything else is untouched.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if ((b >= ASCII_LC_A) && (b <= ASCII_LC_Z)) begin
      r[CASE_BIT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_echo_responder_sync_fifo.sv
// rtl/uart_echo_responder_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Empty is taken from the registered count, so a fresh push becomes poppable one cycle later.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Qualify requests, write the slot at the tail, advance pointers (natural wrap), track occupancy.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: slots are only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - UART byte echo with elastic FIFO; ECHO_UPCASE_EN upper-cases echoed letters
module uart_echo_responder
  import uart_echo_pkg::*;
#(
  parameter  int FIFO_DEPTH   = 16,
  parameter  int BUSY_TIMEOUT = 8,
  localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_50m,
  input  logic          rst,
  input  logic          rx_ready,
  input  logic [7:0]    rx_data,
  output logic          ready_clr,
  input  logic          tx_busy,
  output logic [7:0]    data_in,
  output logic          wr_en,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  output logic          tx_timeout
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  rx_state_t     rx_state_q, rx_state_d;
  tx_state_t     tx_state_q, tx_state_d;
  logic          ready_clr_q, ready_clr_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    data_in_q, data_in_d;
  logic          overflow_q, overflow_d;
  logic          tx_timeout_q, tx_timeout_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic          push;
  logic          pop;
  logic [7:0]    push_data;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

`ifdef ECHO_UPCASE_EN
  assign push_data = to_upper(rx_data);
`else
  assign push_data = rx_data;
`endif

  assign ready_clr  = ready_clr_q;
  assign wr_en      = wr_en_q;
  assign data_in    = data_in_q;
  assign overflow   = overflow_q;
  assign tx_timeout = tx_timeout_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_50m),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // RX side: capture each completed byte once, then wait for the UART to drop rx_ready.
  always_comb begin
    rx_state_d  = rx_state_q;
    ready_clr_d = 1'b0;
    overflow_d  = overflow_q;
    push        = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_ready) begin
          ready_clr_d = 1'b1;
          rx_state_d  = RX_CLR;
          if (!fifo_full) begin
            push = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      RX_CLR: begin
        if (!rx_ready) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX side: pop into data_in, pulse wr_en (registered, so it appears as TX_LOAD is left),
  // then track tx_busy up and down; a byte the UART never accepts is abandoned.
  always_comb begin
    tx_state_d   = tx_state_q;
    wr_en_d      = 1'b0;
    data_in_d    = data_in_q;
    tx_timeout_d = tx_timeout_q;
    tmo_cnt_d    = tmo_cnt_q;
    pop          = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop        = 1'b1;
          data_in_d  = fifo_dout;
          tx_state_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        wr_en_d    = 1'b1;
        tmo_cnt_d  = '0;
        tx_state_d = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (tx_busy) begin
          tx_state_d = TX_WAIT_DONE;
        end else if (tmo_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
          tx_timeout_d = 1'b1;
          tx_state_d   = TX_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      TX_WAIT_DONE: begin
        if (!tx_busy) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // State and output registers; reset leaves any in-flight UART transmission to finish on its own.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      tx_state_q   <= TX_IDLE;
      ready_clr_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      data_in_q    <= 8'h00;
      overflow_q   <= 1'b0;
      tx_timeout_q <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      rx_state_q   <= rx_state_d;
      tx_state_q   <= tx_state_d;
      ready_clr_q  <= ready_clr_d;
      wr_en_q      <= wr_en_d;
      data_in_q    <= data_in_d;
      overflow_q   <= overflow_d;
      tx_timeout_q <= tx_timeout_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_echo_responder.sv
// tb/tb_uart_echo_responder.sv - scoreboard bench for uart_echo_responder (honours ECHO_UPCASE_EN)
module tb_uart_echo_responder;

  localparam int DEPTH  = 4;
  localparam int TMO    = 8;
  localparam int TX_LEN = 40;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk_50m = 1'b0;
  logic          rst = 1'b1;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_busy;
  logic          ready_clr;
  logic [7:0]    data_in;
  logic          wr_en;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          tx_timeout;

  logic       force_busy = 1'b0;
  logic       model_busy = 1'b0;
  logic       pend = 1'b0;
  int         busy_left = 0;
  int         tx_mode = 0;
  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         cycle_cnt = 0;
  int         last_wr_cyc = -1;
  int         send_cyc = 0;
  int         clr_pulses = 0;
  int         peak_count = 0;
  logic [7:0] mon_exp;
  logic [7:0] exp_q[$];

  assign tx_busy = force_busy | model_busy;

  uart_echo_responder #(
    .FIFO_DEPTH   (DEPTH),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .ready_clr  (ready_clr),
    .tx_busy    (tx_busy),
    .data_in    (data_in),
    .wr_en      (wr_en),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .tx_timeout (tx_timeout)
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cycle_cnt = cycle_cnt + 1;

  // UART transmitter model: busy rises a cycle after wr_en and lasts TX_LEN cycles (mode 0),
  // or never rises (mode 1).
  always @(negedge clk_50m) begin
    if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) model_busy = 1'b0;
    end
    if (pend) begin
      pend       = 1'b0;
      model_busy = 1'b1;
      busy_left  = TX_LEN;
    end
    if (wr_en && tx_mode == 0) pend = 1'b1;
  end

  // Monitor: every wr_en pulse is checked against the head of the expected queue.
  always @(negedge clk_50m) begin
    if (!rst) begin
      if (ready_clr) clr_pulses = clr_pulses + 1;
      if (int'(fifo_count) > peak_count) peak_count = int'(fifo_count);
      if (wr_en) begin
        last_wr_cyc = cycle_cnt;
        vec_cnt = vec_cnt + 1;
        if (exp_q.size() == 0) begin
          err_cnt = err_cnt + 1;
          $display("FAIL echo: wr_en with data_in=%02h, none required", data_in);
        end else begin
          mon_exp = exp_q.pop_front();
          if (data_in !== mon_exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL echo: data_in=%02h required %02h", data_in, mon_exp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vec_cnt = vec_cnt + 1;
    if (act != exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    @(posedge clk_50m);
    #1;
    rx_data  = b;
    rx_ready = 1'b1;
    send_cyc = cycle_cnt;
    for (k = 0; k < 20; k++) begin
      @(negedge clk_50m);
      if (ready_clr) break;
    end
    if (k == 20) begin
      vec_cnt = vec_cnt + 1;
      err_cnt = err_cnt + 1;
      $display("FAIL handshake: no ready_clr for byte %02h, required within 20 cycles", b);
    end
    @(posedge clk_50m);
    #1;
    rx_ready = 1'b0;
    @(posedge clk_50m);
  endtask

  task automatic drain(input string name, input int budget);
    int stable;
    int k;
    stable = 0;
    for (k = 0; k < budget; k++) begin
      @(negedge clk_50m);
      if (exp_q.size() == 0 && !tx_busy && !pend && fifo_count == '0) stable = stable + 1;
      else stable = 0;
      if (stable >= 4) break;
    end
    vec_cnt = vec_cnt + 1;
    if (stable < 4) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: %0d echoes outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset state
    repeat (3) @(posedge clk_50m);
    @(negedge clk_50m);
    check("rst_ready_clr", int'(ready_clr), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_data_in", int'(data_in), 8'h00);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_tx_timeout", int'(tx_timeout), 0);
    @(posedge clk_50m);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk_50m);

    // Single byte: latency, single ready_clr pulse, FIFO returns to empty
    clr_pulses = 0;
    exp_q.push_back(8'hAB);
    send_byte(8'hAB);
    drain("single_drain", 200);
    check("single_latency", last_wr_cyc - send_cyc, 3);
    check("single_clr_pulses", clr_pulses, 1);
    check("single_fifo_count", int'(fifo_count), 0);

    // Incrementing stream faster than the transmitter drains it
    peak_count = 0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i));
      repeat (32) @(posedge clk_50m);
    end
    drain("stream_drain", 2000);
    check("stream_peak_ge2", int'(peak_count >= 2), 1);
    check("stream_overflow", int'(overflow), 0);

    // Overflow with transmitter held busy
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i));
    end
    @(negedge clk_50m);
    check("ovf_fifo_count", int'(fifo_count), 4);
    check("ovf_overflow", int'(overflow), 1);
    force_busy = 1'b0;
    drain("ovf_drain", 1000);
    check("ovf_overflow_sticky", int'(overflow), 1);

    // Transmitter never acknowledges: timeout after TMO cycles in TX_WAIT_BUSY
    tx_mode = 1;
    exp_q.push_back(8'h3F);
    send_byte(8'h3F);
    for (k = 0; k < 20; k++) begin
      if (wr_en) break;
      @(negedge clk_50m);
    end
    check("tmo_wr_en_seen", int'(k < 20), 1);
    repeat (TMO - 1) @(negedge clk_50m);
    check("tmo_not_yet", int'(tx_timeout), 0);
    @(negedge clk_50m);
    check("tmo_set", int'(tx_timeout), 1);
    tx_mode = 0;
    exp_q.push_back(8'h40);
    send_byte(8'h40);
    drain("tmo_next_drain", 200);
    check("tmo_sticky", int'(tx_timeout), 1);

    // Reset during a transmission with two bytes queued
    exp_q.push_back(8'h21);
    send_byte(8'h21);
    send_byte(8'h22);
    send_byte(8'h23);
    @(negedge clk_50m);
    check("mid_rst_queued", int'(fifo_count), 2);
    check("mid_rst_busy", int'(tx_busy), 1);
    exp_q.delete();
    @(posedge clk_50m);
    #1 rst = 1'b1;
    @(posedge clk_50m);
    #1 rst = 1'b0;
    @(negedge clk_50m);
    check("mid_rst_ready_clr", int'(ready_clr), 0);
    check("mid_rst_wr_en", int'(wr_en), 0);
    check("mid_rst_data_in", int'(data_in), 8'h00);
    check("mid_rst_fifo_count", int'(fifo_count), 0);
    check("mid_rst_overflow", int'(overflow), 0);
    check("mid_rst_tx_timeout", int'(tx_timeout), 0);
    for (k = 0; k < 100; k++) begin
      if (!tx_busy) break;
      @(negedge clk_50m);
    end
    check("mid_rst_busy_drops", int'(k < 100), 1);
    repeat (5) @(negedge clk_50m);
    check("mid_rst_still_empty", int'(fifo_count), 0);
    exp_q.push_back(8'h55);
    send_byte(8'h55);
    drain("mid_rst_drain", 200);

    // Case conversion on the push path
`ifdef ECHO_UPCASE_EN
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5B);
`else
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h7A);
    exp_q.push_back(8'h5B);
`endif
    send_byte(8'h61);
    send_byte(8'h7A);
    send_byte(8'h5B);
    drain("case_drain", 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
